affine_addr_sched: RTL and testbench

- Multi-channel scheduler for the 2D affine address stream: addr = offset + x*x_stride + y*y_stride, with x inner (0..x_max-1) and y outer (0..y_max-1).
- Holds one configuration per channel and arbitrates round-robin among started channels.
- Runs one full, non-preemptive sweep per grant and emits addresses on a valid/ready stream tagged with channel id and last.
- Replaces the multipliers with incremental accumulation and adds completion handshaking.

---
 rtl/affine_addr_sched.sv | 211 +++++++++++++++++++++
 tb/tb_affine_addr_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/affine_addr_sched.sv
// Round-robin multi-channel 2D affine address generator (addr = off + x*xs + y*ys).
// Each grant runs one non-preemptive sweep from a config snapshot using adders only.
module affine_addr_sched #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [2:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic [NUM_CH-1:0] start,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_cfg_off  [NUM_CH];
  logic [ADDR_W-1:0] r_cfg_xmax [NUM_CH];
  logic [ADDR_W-1:0] r_cfg_xstr [NUM_CH];
  logic [ADDR_W-1:0] r_cfg_ymax [NUM_CH];
  logic [ADDR_W-1:0] r_cfg_ystr [NUM_CH];

  logic [ADDR_W-1:0] r_s_xmax, r_s_xstr, r_s_ymax, r_s_ystr;
  logic [ADDR_W-1:0] r_x, r_y, r_row, r_cur;
  logic [CH_W-1:0]   r_grant, r_rr, r_ch;
  logic [NUM_CH-1:0] r_pending, r_done;
  logic              r_valid, r_last;
  logic [ADDR_W-1:0] r_addr;

  logic [ADDR_W-1:0] w_s_xmax, w_s_xstr, w_s_ymax, w_s_ystr;
  logic [ADDR_W-1:0] w_x, w_y, w_row, w_cur, w_addr;
  logic [CH_W-1:0]   w_grant, w_rr, w_ch, w_gnt, w_gnt_inc;
  logic [NUM_CH-1:0] w_pend_clr, w_done;
  logic              w_valid, w_last, w_found;
  int unsigned       w_idx;

  // Config register file; writes land at any time, sweeps use the snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_cfg_off[i]  <= '0;
        r_cfg_xmax[i] <= '0;
        r_cfg_xstr[i] <= '0;
        r_cfg_ymax[i] <= '0;
        r_cfg_ystr[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      case (cfg_field)
        3'd0:    r_cfg_off[cfg_ch]  <= cfg_wdata;
        3'd1:    r_cfg_xmax[cfg_ch] <= cfg_wdata;
        3'd2:    r_cfg_xstr[cfg_ch] <= cfg_wdata;
        3'd3:    r_cfg_ymax[cfg_ch] <= cfg_wdata;
        3'd4:    r_cfg_ystr[cfg_ch] <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // First pending channel at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = 32'(r_rr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_found && r_pending[CH_W'(w_idx)]) begin
        w_found = 1'b1;
        w_gnt   = CH_W'(w_idx);
      end
    end
    w_gnt_inc = ((32'(w_gnt) + 32'd1) >= NUM_CH) ? '0 : CH_W'(32'(w_gnt) + 32'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_s_xmax    = r_s_xmax;
    w_s_xstr    = r_s_xstr;
    w_s_ymax    = r_s_ymax;
    w_s_ystr    = r_s_ystr;
    w_x         = r_x;
    w_y         = r_y;
    w_row       = r_row;
    w_cur       = r_cur;
    w_grant     = r_grant;
    w_rr        = r_rr;
    w_ch        = r_ch;
    w_valid     = r_valid;
    w_addr      = r_addr;
    w_last      = r_last;
    w_done      = '0;
    w_pend_clr  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant  = w_gnt;
          w_rr     = w_gnt_inc;
          w_s_xmax = r_cfg_xmax[w_gnt];
          w_s_xstr = r_cfg_xstr[w_gnt];
          w_s_ymax = r_cfg_ymax[w_gnt];
          w_s_ystr = r_cfg_ystr[w_gnt];
          w_x      = '0;
          w_y      = '0;
          w_row    = r_cfg_off[w_gnt];
          w_cur    = r_cfg_off[w_gnt];
          if (r_cfg_xmax[w_gnt] == '0 || r_cfg_ymax[w_gnt] == '0) begin
            w_state_nxt = S_DONE;
            w_done      = NUM_CH'(1) << w_gnt;
          end else begin
            w_state_nxt = S_RUN;
            w_valid     = 1'b1;
            w_addr      = r_cfg_off[w_gnt];
            w_ch        = w_gnt;
            w_last      = (r_cfg_xmax[w_gnt] == ONE) && (r_cfg_ymax[w_gnt] == ONE);
          end
        end
      end
      S_RUN: begin
        if (r_valid && out_ready) begin
          if (r_last) begin
            w_state_nxt = S_DONE;
            w_valid     = 1'b0;
            w_last      = 1'b0;
            w_done      = NUM_CH'(1) << r_grant;
          end else begin
            if (r_x != r_s_xmax - ONE) begin
              w_x   = r_x + ONE;
              w_cur = r_cur + r_s_xstr;
            end else begin
              w_x   = '0;
              w_y   = r_y + ONE;
              w_row = r_row + r_s_ystr;
              w_cur = r_row + r_s_ystr;
            end
            w_addr = w_cur;
            w_last = (w_x == r_s_xmax - ONE) && (w_y == r_s_ymax - ONE);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_pend_clr  = NUM_CH'(1) << r_grant;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A start in the DONE cycle keeps the channel pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_xmax  <= '0;
      r_s_xstr  <= '0;
      r_s_ymax  <= '0;
      r_s_ystr  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_row     <= '0;
      r_cur     <= '0;
      r_grant   <= '0;
      r_rr      <= '0;
      r_ch      <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_last    <= 1'b0;
      r_done    <= '0;
      r_pending <= '0;
    end else begin
      r_s_xmax  <= w_s_xmax;
      r_s_xstr  <= w_s_xstr;
      r_s_ymax  <= w_s_ymax;
      r_s_ystr  <= w_s_ystr;
      r_x       <= w_x;
      r_y       <= w_y;
      r_row     <= w_row;
      r_cur     <= w_cur;
      r_grant   <= w_grant;
      r_rr      <= w_rr;
      r_ch      <= w_ch;
      r_valid   <= w_valid;
      r_addr    <= w_addr;
      r_last    <= w_last;
      r_done    <= w_done;
      r_pending <= start | (r_pending & ~w_pend_clr);
    end
  end

  assign busy      = r_pending;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_ch    = r_ch;
  assign out_last  = r_last;

endmodule

// File: tb/tb_affine_addr_sched.sv
// Bench for affine_addr_sched: stream and done events compared against a
// multiply-based sweep model with round-robin ordering.
module tb_affine_addr_sched;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int CH_W   = 1;

  typedef logic [ADDR_W+CH_W:0] hs_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [2:0]        cfg_field = '0;
  logic [ADDR_W-1:0] cfg_wdata = '0;
  logic [NUM_CH-1:0] start = '0;
  logic [NUM_CH-1:0] busy, done;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [CH_W-1:0]   out_ch;

  affine_addr_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .start(start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_ch(out_ch), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [ADDR_W-1:0] m_cfg [NUM_CH][5];
  int                m_rr;
  hs_t               e_hs[$];
  logic [NUM_CH-1:0] e_done[$];

  // Observations
  hs_t               h_hs[$];
  int                h_it[$];
  logic [NUM_CH-1:0] d_val[$];
  int                d_it[$];
  int                stall_err, valid_seen;
  logic              timed_out;
  logic [NUM_CH-1:0] busy1;

  // Stimulus schedule for run()
  int                g_start_at, g_start2_at, g_wr_at, g_ready_mode;
  logic [NUM_CH-1:0] g_start_mask, g_start2_mask;
  int                g_wr_ch, g_wr_field;
  logic [ADDR_W-1:0] g_wr_data;
  logic [7:0]        bp_pat = 8'b1110_1001;

  function automatic void model_sweep(int ch);
    logic [ADDR_W-1:0] off, xm, xs, ym, ys, a;
    off = m_cfg[ch][0]; xm = m_cfg[ch][1]; xs = m_cfg[ch][2];
    ym = m_cfg[ch][3]; ys = m_cfg[ch][4];
    for (longint y = 0; y < longint'(ym); y++) begin
      for (longint x = 0; x < longint'(xm); x++) begin
        a = off + ADDR_W'(x) * xs + ADDR_W'(y) * ys;
        e_hs.push_back({(x == longint'(xm) - 1) && (y == longint'(ym) - 1), CH_W'(ch), a});
      end
    end
    e_done.push_back(NUM_CH'(1) << ch);
  endfunction

  // Channels requested together are served in round-robin order
  function automatic void model_run(logic [NUM_CH-1:0] mask);
    logic [NUM_CH-1:0] rem;
    int rr;
    rem = mask;
    rr  = m_rr;
    while (rem != '0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (rr + k) % NUM_CH;
        if (rem[c]) begin
          model_sweep(c);
          rem[c] = 1'b0;
          rr = (c + 1) % NUM_CH;
          break;
        end
      end
    end
    m_rr = rr;
  endfunction

  task automatic model_clear();
    e_hs.delete();
    e_done.delete();
  endtask

  task automatic sched_clear();
    g_start_at = -1; g_start2_at = -1; g_wr_at = -1; g_ready_mode = 0;
    g_start_mask = '0; g_start2_mask = '0;
    g_wr_ch = 0; g_wr_field = 0; g_wr_data = '0;
  endtask

  task automatic cfg_write(input int ch, input int field, input logic [ADDR_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_field = 3'(field); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (ch < NUM_CH && field < 5) m_cfg[ch][field] = d;
  endtask

  task automatic set_cfg(input int ch, input logic [ADDR_W-1:0] off, input logic [ADDR_W-1:0] xm,
                         input logic [ADDR_W-1:0] xs, input logic [ADDR_W-1:0] ym,
                         input logic [ADDR_W-1:0] ys);
    cfg_write(ch, 0, off);
    cfg_write(ch, 1, xm);
    cfg_write(ch, 2, xs);
    cfg_write(ch, 3, ym);
    cfg_write(ch, 4, ys);
  endtask

  // Drive and observe one negedge per iteration until enough done/handshake events
  task automatic run(input int n_done, input int n_hs, input int budget);
    int vcount;
    logic pv, pr, pl, r;
    logic [ADDR_W-1:0] pa;
    logic [CH_W-1:0] pc;
    h_hs.delete(); h_it.delete(); d_val.delete(); d_it.delete();
    stall_err = 0; valid_seen = 0; timed_out = 1'b1; busy1 = '0;
    vcount = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pc = '0;
    for (int it = 0; it < budget; it++) begin
      @(negedge clk);
      if (it == g_start_at)       start = g_start_mask;
      else if (it == g_start2_at) start = g_start2_mask;
      else                        start = '0;
      cfg_we = (it == g_wr_at);
      cfg_ch = CH_W'(g_wr_ch); cfg_field = 3'(g_wr_field); cfg_wdata = g_wr_data;
      if (it == 1) busy1 = busy;
      if (done !== '0) begin d_val.push_back(done); d_it.push_back(it); end
      if (pv && !pr && (out_valid !== 1'b1 || out_addr !== pa || out_ch !== pc || out_last !== pl))
        stall_err++;
      case (g_ready_mode)
        0:       r = 1'b1;
        1:       r = (vcount < 8) ? bp_pat[3'(vcount)] : 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1) begin valid_seen++; vcount++; end
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        h_hs.push_back({out_last, out_ch, out_addr});
        h_it.push_back(it);
      end
      pv = out_valid; pr = r; pa = out_addr; pc = out_ch; pl = out_last;
      if ((n_done > 0 && d_val.size() >= n_done) || (n_hs > 0 && h_hs.size() >= n_hs)) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = '0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", out_addr); end
    checks++; if (out_ch !== '0) begin failures++; $display("FAIL reset_ch got=%h exp=0", out_ch); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== '0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    m_rr = 0;
    for (int c = 0; c < NUM_CH; c++) for (int f = 0; f < 5; f++) m_cfg[c][f] = '0;
  endtask

  task automatic test_round_robin();
    set_cfg(0, 32'd0, 32'd2, 32'd4, 32'd1, 32'd0);
    set_cfg(1, 32'd1000, 32'd2, 32'd3, 32'd1, 32'd0);
    for (int round = 0; round < 3; round++) begin
      sched_clear(); model_clear();
      g_start_at = 0;
      if (round < 2) begin
        g_start_mask = 2'b11;
        model_run(2'b11);
      end else begin
        g_start_mask = 2'b01; g_start2_at = 3; g_start2_mask = 2'b10;
        model_run(2'b01); model_run(2'b10);
      end
      run(2, 0, 100);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rr%0d_timeout got=1 exp=0", round); end
      if (round < 2) begin
        checks++; if (busy1 !== 2'b11) begin failures++; $display("FAIL rr%0d_busy got=%b exp=11", round, busy1); end
      end
      checks++; if (h_hs.size() !== e_hs.size()) begin failures++; $display("FAIL rr%0d_count got=%0d exp=%0d", round, h_hs.size(), e_hs.size()); end
      for (int i = 0; i < e_hs.size() && i < h_hs.size(); i++) begin
        checks++; if (h_hs[i] !== e_hs[i]) begin failures++; $display("FAIL rr%0d_hs[%0d] got=%h exp=%h", round, i, h_hs[i], e_hs[i]); end
      end
      for (int i = 0; i < e_done.size() && i < d_val.size(); i++) begin
        checks++; if (d_val[i] !== e_done[i]) begin failures++; $display("FAIL rr%0d_done[%0d] got=%b exp=%b", round, i, d_val[i], e_done[i]); end
      end
      if (round == 2 && d_it.size() > 0 && h_it.size() == 4) begin
        checks++; if (h_it[2] !== d_it[0] + 2) begin failures++; $display("FAIL rr_follow_on got=%0d exp=%0d", h_it[2], d_it[0] + 2); end
      end
    end
  endtask

  task automatic test_basic();
    sched_clear(); model_clear();
    set_cfg(0, 32'd100, 32'd3, 32'd4, 32'd2, 32'd16);
    model_run(2'b01);
    g_start_at = 0; g_start_mask = 2'b01;
    run(1, 0, 100);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (h_hs.size() !== 6) begin failures++; $display("FAIL basic_count got=%0d exp=6", h_hs.size()); end
    for (int i = 0; i < e_hs.size() && i < h_hs.size(); i++) begin
      checks++; if (h_hs[i] !== e_hs[i]) begin failures++; $display("FAIL basic_hs[%0d] got=%h exp=%h", i, h_hs[i], e_hs[i]); end
      checks++; if (h_it[i] !== 2 + i) begin failures++; $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", i, h_it[i], 2 + i); end
    end
    if (d_val.size() > 0) begin
      checks++; if (d_val[0] !== 2'b01) begin failures++; $display("FAIL basic_done got=%b exp=01", d_val[0]); end
      checks++; if (d_it[0] !== 8) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=8", d_it[0]); end
    end
    @(negedge clk);
    checks++; if (done !== '0) begin failures++; $display("FAIL basic_done_width got=%b exp=00", done); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL basic_busy_after got=%b exp=00", busy); end
  endtask

  task automatic test_backpressure();
    sched_clear(); model_clear();
    model_run(2'b01);
    g_start_at = 0; g_start_mask = 2'b01; g_ready_mode = 1;
    run(1, 0, 100);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    checks++; if (h_hs.size() !== e_hs.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", h_hs.size(), e_hs.size()); end
    for (int i = 0; i < e_hs.size() && i < h_hs.size(); i++) begin
      checks++; if (h_hs[i] !== e_hs[i]) begin failures++; $display("FAIL bp_hs[%0d] got=%h exp=%h", i, h_hs[i], e_hs[i]); end
    end
  endtask

  task automatic test_zero_extent();
    for (int k = 0; k < 2; k++) begin
      sched_clear(); model_clear();
      if (k == 0) begin cfg_write(1, 1, 32'd0); cfg_write(1, 3, 32'd3); end
      else        begin cfg_write(1, 1, 32'd2); cfg_write(1, 3, 32'd0); end
      model_run(2'b10);
      g_start_at = 0; g_start_mask = 2'b10;
      run(1, 0, 50);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL zero%0d_timeout got=1 exp=0", k); end
      checks++; if (valid_seen !== 0) begin failures++; $display("FAIL zero%0d_valid got=%0d exp=0", k, valid_seen); end
      if (d_val.size() > 0) begin
        checks++; if (d_val[0] !== e_done[0]) begin failures++; $display("FAIL zero%0d_done got=%b exp=%b", k, d_val[0], e_done[0]); end
        checks++; if (d_it[0] !== 2) begin failures++; $display("FAIL zero%0d_done_cycle got=%0d exp=2", k, d_it[0]); end
      end
      @(negedge clk);
      checks++; if (done !== '0) begin failures++; $display("FAIL zero%0d_done_width got=%b exp=00", k, done); end
    end
  endtask

  task automatic test_config_wrap();
    set_cfg(0, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    for (int k = 0; k < 2; k++) begin
      sched_clear(); model_clear();
      model_run(2'b01);
      g_start_at = 0; g_start_mask = 2'b01;
      if (k == 0) begin g_wr_at = 3; g_wr_ch = 0; g_wr_field = 2; g_wr_data = 32'd8; end
      run(1, 0, 100);
      if (k == 0) m_cfg[0][2] = 32'd8;
      checks++; if (h_hs.size() !== e_hs.size()) begin failures++; $display("FAIL wrap%0d_count got=%0d exp=%0d", k, h_hs.size(), e_hs.size()); end
      for (int i = 0; i < e_hs.size() && i < h_hs.size(); i++) begin
        checks++; if (h_hs[i] !== e_hs[i]) begin failures++; $display("FAIL wrap%0d_hs[%0d] got=%h exp=%h", k, i, h_hs[i], e_hs[i]); end
      end
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] mask;
    for (int n = 0; n < 8; n++) begin
      sched_clear(); model_clear();
      for (int c = 0; c < NUM_CH; c++) begin
        set_cfg(c, $urandom, 32'($urandom_range(0, 4)), $urandom, 32'($urandom_range(0, 4)), $urandom);
        cfg_write(c, $urandom_range(5, 7), $urandom);
      end
      mask = NUM_CH'($urandom_range(1, 3));
      model_run(mask);
      g_start_at = 0; g_start_mask = mask; g_ready_mode = 2;
      run($countones(mask), 0, 400);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout got=1 exp=0", n); end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL rand%0d_stable got=%0d exp=0", n, stall_err); end
      checks++; if (h_hs.size() !== e_hs.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, h_hs.size(), e_hs.size()); end
      for (int i = 0; i < e_hs.size() && i < h_hs.size(); i++) begin
        checks++; if (h_hs[i] !== e_hs[i]) begin failures++; $display("FAIL rand%0d_hs[%0d] got=%h exp=%h", n, i, h_hs[i], e_hs[i]); end
      end
      for (int i = 0; i < e_done.size() && i < d_val.size(); i++) begin
        checks++; if (d_val[i] !== e_done[i]) begin failures++; $display("FAIL rand%0d_done[%0d] got=%b exp=%b", n, i, d_val[i], e_done[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    sched_clear(); model_clear();
    set_cfg(0, 32'd100, 32'd3, 32'd4, 32'd2, 32'd16);
    model_run(2'b01);
    g_start_at = 0; g_start_mask = 2'b01;
    run(0, 3, 100);
    for (int i = 0; i < 3 && i < h_hs.size(); i++) begin
      checks++; if (h_hs[i] !== e_hs[i]) begin failures++; $display("FAIL rstmid_hs[%0d] got=%h exp=%h", i, h_hs[i], e_hs[i]); end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL rstmid_busy got=%b exp=00", busy); end
    checks++; if (done !== '0) begin failures++; $display("FAIL rstmid_done got=%b exp=00", done); end
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
    for (int c = 0; c < NUM_CH; c++) for (int f = 0; f < 5; f++) m_cfg[c][f] = '0;
    sched_clear(); model_clear();
    model_run(2'b01);
    g_start_at = 0; g_start_mask = 2'b01;
    run(1, 0, 50);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rstmid_restart_timeout got=1 exp=0"); end
    checks++; if (valid_seen !== 0) begin failures++; $display("FAIL rstmid_cfg_zero got=%0d exp=0", valid_seen); end
    if (d_val.size() > 0) begin
      checks++; if (d_val[0] !== e_done[0]) begin failures++; $display("FAIL rstmid_restart_done got=%b exp=%b", d_val[0], e_done[0]); end
    end
  endtask

  initial begin
    sched_clear();
    test_reset();
    test_round_robin();
    test_basic();
    test_backpressure();
    test_zero_extent();
    test_config_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
